// File: rtl/sa_cache_tag_table.sv
// N-way set-associative tag store with true-LRU ages, a registered hit/victim lookup,
// a direct entry write port and a hardware invalidate-all sweep.

module sa_tag_way_cmp #(
  parameter int TAG_W = 18
) (
  input  logic             valid,
  input  logic [TAG_W-1:0] tag,
  input  logic [TAG_W-1:0] req_tag,
  output logic             match
);
  assign match = valid && (tag == req_tag);
endmodule

module sa_cache_tag_table #(
  parameter int WAYS  = 2,
  parameter int SETS  = 256,
  parameter int TAG_W = 18,
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] req_index,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [WAY_W-1:0] rsp_way,
  output logic             rsp_vic_valid,
  output logic             rsp_vic_dirty,
  output logic [TAG_W-1:0] rsp_vic_tag,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [WAY_W-1:0] wr_way,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_valid,
  input  logic             wr_dirty,
  input  logic             flush_start,
  output logic             flush_busy,
  output logic             flush_done
);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  typedef logic [WAYS-1:0][WAY_W-1:0] age_t;
  typedef logic [WAYS-1:0][TAG_W-1:0] tags_t;

  function automatic age_t age_reset();
    age_t r;
    for (int w = 0; w < WAYS; w++) r[w] = WAY_W'(w);
    return r;
  endfunction

  // Touched way becomes MRU; only ways younger than it age by one.
  function automatic age_t touch(input age_t a, input logic [WAY_W-1:0] w);
    age_t r;
    r = a;
    for (int v = 0; v < WAYS; v++) begin
      if (WAY_W'(v) == w)   r[v] = '0;
      else if (a[v] < a[w]) r[v] = a[v] + WAY_W'(1);
    end
    return r;
  endfunction

  localparam age_t AGE_INIT = age_reset();

  tags_t             tag_mem   [SETS];
  logic [WAYS-1:0]   valid_mem [SETS];
  logic [WAYS-1:0]   dirty_mem [SETS];
  age_t              age_mem   [SETS];

  logic [0:0]        state;
  logic [IDX_W-1:0]  cnt;

  tags_t             rd_tag;
  logic [WAYS-1:0]   rd_valid;
  logic [WAYS-1:0]   rd_dirty;
  age_t              rd_age;
  logic [WAYS-1:0]   match;
  logic              hit, inv_any, accept;
  logic [WAY_W-1:0]  hit_way, inv_way, lru_way, vic_way;

  assign req_ready  = (state == ST_IDLE);
  assign flush_busy = (state == ST_SWEEP);
  assign accept     = req_valid && req_ready;

  assign rd_tag   = tag_mem[req_index];
  assign rd_valid = valid_mem[req_index];
  assign rd_dirty = dirty_mem[req_index];
  assign rd_age   = age_mem[req_index];

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    sa_tag_way_cmp #(.TAG_W(TAG_W)) u_cmp (
      .valid   (rd_valid[g]),
      .tag     (rd_tag[g]),
      .req_tag (req_tag),
      .match   (match[g])
    );
  end

  // Downward scans so the lowest-numbered qualifying way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    lru_way = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (match[w]) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!rd_valid[w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
      if (rd_age[w] == WAY_W'(WAYS-1)) lru_way = WAY_W'(w);
    end
    vic_way = inv_any ? inv_way : lru_way;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_SWEEP;
      cnt           <= '0;
      flush_done    <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_hit       <= 1'b0;
      rsp_way       <= '0;
      rsp_vic_valid <= 1'b0;
      rsp_vic_dirty <= 1'b0;
      rsp_vic_tag   <= '0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        ST_SWEEP: begin
          cnt <= cnt + IDX_W'(1);
          if (cnt == IDX_W'(SETS-1)) begin
            state      <= ST_IDLE;
            flush_done <= 1'b1;
          end
        end
        default: begin
          if (flush_start) begin
            state <= ST_SWEEP;
            cnt   <= '0;
          end
        end
      endcase
      rsp_valid     <= accept;
      rsp_hit       <= accept && hit;
      rsp_way       <= accept ? (hit ? hit_way : vic_way) : '0;
      rsp_vic_valid <= accept && !hit && rd_valid[vic_way];
      rsp_vic_dirty <= accept && !hit && rd_dirty[vic_way];
      rsp_vic_tag   <= (accept && !hit) ? rd_tag[vic_way] : '0;
    end
  end

  // Storage is cleared by the sweep, not by reset. The write's LRU update is
  // issued last so it overrides a same-set hit update.
  always_ff @(posedge clk) begin
    if (state == ST_SWEEP) begin
      valid_mem[cnt] <= '0;
      dirty_mem[cnt] <= '0;
      age_mem[cnt]   <= AGE_INIT;
    end else begin
      if (req_valid && hit) age_mem[req_index] <= touch(rd_age, hit_way);
      if (wr_en) begin
        tag_mem[wr_index][wr_way]   <= wr_tag;
        valid_mem[wr_index][wr_way] <= wr_valid;
        dirty_mem[wr_index][wr_way] <= wr_dirty;
        age_mem[wr_index]           <= touch(age_mem[wr_index], wr_way);
      end
    end
  end

endmodule
